// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, word-organised memory between instruction fetch (IF)
// and data load/store (D). Each access walks IDLE -> ISSUE (-> WAIT for reads)
// and every requester-facing output is registered.
//
// Optional feature macro: ARB_FAIRNESS_EN
//   Defined   : a starve counter lets IF win a conflict after MAX_WAIT
//               consecutive D grants that were made while IF was waiting.
//   Undefined : strict D priority; IF can starve.
//
// Handshake: a requester raises req (with its address/data) and holds it until
// it sees its 1-cycle gnt pulse, then drops req in that same cycle. A req seen
// while busy is ignored, not queued. Read data is returned with a 1-cycle valid
// pulse two cycles after gnt; stores produce no valid.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request and byte address
//   if_gnt/if_valid/if_rdata   fetch accept pulse, data pulse, fetched word
//   d_req/d_we/d_addr/d_wdata  data request, store flag, byte address, store data
//   d_gnt/d_valid/d_rdata      data accept pulse, load data pulse, load word
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata        memory array port (1-cycle read latency)
//   busy                       high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Access latched at grant time; owner_d is 1 when D owns the access.
    logic              owner_d;
    logic [ADDR_W-3:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;

    logic grant_if;
    logic grant_d;
    logic if_turn;

    // Byte-offset bits are deliberately dropped; MAX_WAIT only matters when
    // the fairness counter is built.
    logic unused_bits;
    assign unused_bits = &{1'b0, if_addr[1:0], d_addr[1:0], (MAX_WAIT == 0)};

`ifdef ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    // Counts D grants made while IF was also asking; saturates at MAX_WAIT,
    // at which point the next conflict goes to IF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && if_req && (starve_cnt != CNT_W'(MAX_WAIT))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign if_turn = (starve_cnt == CNT_W'(MAX_WAIT));
`else
    assign if_turn = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and grant decision. D normally wins a conflict because its
    // instruction is older (already in MEM).
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (d_req && !(if_req && if_turn)) begin
                    grant_d    = 1'b1;
                    state_next = S_ISSUE;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = we_q ? S_IDLE : S_WAIT;
            S_WAIT:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Memory port is only driven during ISSUE; zero otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == S_ISSUE) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
    end

    assign busy = (state != S_IDLE);

    // Access latches, grant pulses and read-data return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_gnt   <= grant_if;
            d_gnt    <= grant_d;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            if (grant_d) begin
                owner_d <= 1'b1;
                addr_q  <= d_addr[ADDR_W-1:2];
                wdata_q <= d_wdata;
                we_q    <= d_we;
            end else if (grant_if) begin
                owner_d <= 1'b0;
                addr_q  <= if_addr[ADDR_W-1:2];
                wdata_q <= '0;
                we_q    <= 1'b0;
            end

            // mem_rdata belongs to the read issued one cycle earlier.
            if (state == S_WAIT) begin
                if (owner_d) begin
                    d_rdata <= mem_rdata;
                    d_valid <= 1'b1;
                end else begin
                    if_rdata <= mem_rdata;
                    if_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. Drivers issue IF/D requests and, on grant,
// compute the expected read word from a reference memory array and push it
// (with the cycle it must appear in) onto per-port expected queues. A monitor
// pops those queues whenever a valid pulse appears. A separate 1-cycle-latency
// memory array sits on the DUT's memory port. Honours ARB_FAIRNESS_EN.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int WORDS    = 64;
    localparam int TIMEOUT  = 300;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // {expected cycle, expected data}
    logic [63:0] if_exp_q[$];
    logic [63:0] d_exp_q[$];

    logic [31:0] ref_mem [WORDS];
    logic [31:0] mem_arr [WORDS];
    logic [31:0] seed;

    int if_acc_cnt = 0;
    int d_acc_cnt  = 0;
    int if_gnt_cnt = 0;
    int d_gnt_cnt  = 0;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'h00402103;
        return seed ^ (32'(i) * 32'h9E3779B1);
    endfunction

    // Memory array behind the DUT: 1-cycle read latency, re-seeded in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) mem_arr[i] <= init_word(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    task automatic reinit_ref();
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    endtask

    // ---------------- driver tasks ----------------
    task automatic if_access(input logic [7:0] addr, output int gcyc);
        int n;
        n = 0;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = addr;
        do begin
            @(negedge clk);
            n++;
        end while (!if_gnt && n < TIMEOUT);
        if_req = 1'b0;
        gcyc   = cyc;
        checks++;
        if (!if_gnt) begin
            errors++;
            gcyc = -1;
            $display("FAIL if_gnt_timeout: addr=%h got no grant in %0d cycles, required a grant", addr, TIMEOUT);
            return;
        end
        if_acc_cnt++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addr[7:2]) begin
            errors++;
            $display("FAIL if_issue: en=%b we=%b addr=%0d, required en=1 we=0 addr=%0d",
                     mem_en, mem_we, mem_addr, addr[7:2]);
        end
        if_exp_q.push_back({32'(cyc + 2), ref_mem[addr[7:2]]});
    endtask

    task automatic d_access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                            output int gcyc);
        int n;
        n = 0;
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        do begin
            @(negedge clk);
            n++;
        end while (!d_gnt && n < TIMEOUT);
        d_req = 1'b0;
        gcyc  = cyc;
        checks++;
        if (!d_gnt) begin
            errors++;
            gcyc = -1;
            $display("FAIL d_gnt_timeout: addr=%h got no grant in %0d cycles, required a grant", addr, TIMEOUT);
            return;
        end
        d_acc_cnt++;
        if (mem_en !== 1'b1 || mem_we !== we || mem_addr !== addr[7:2] ||
            (we && mem_wdata !== wdata)) begin
            errors++;
            $display("FAIL d_issue: en=%b we=%b addr=%0d wdata=%h, required en=1 we=%b addr=%0d wdata=%h",
                     mem_en, mem_we, mem_addr, mem_wdata, we, addr[7:2], wdata);
        end
        if (we) ref_mem[addr[7:2]] = wdata;
        else    d_exp_q.push_back({32'(cyc + 2), ref_mem[addr[7:2]]});
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy} !== 7'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL %s: gnt=%b%b valid=%b%b en=%b we=%b busy=%b addr=%0d wdata=%h ird=%h drd=%h, required all 0",
                     name, if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, busy,
                     mem_addr, mem_wdata, if_rdata, d_rdata);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((busy || if_exp_q.size() != 0 || d_exp_q.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || if_exp_q.size() != 0 || d_exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: busy=%b pending if=%0d d=%0d, required idle with none pending",
                     name, busy, if_exp_q.size(), d_exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (rst_n) begin
            if (if_gnt) if_gnt_cnt++;
            if (d_gnt)  d_gnt_cnt++;
            checks++;
            if (mem_en !== (if_gnt | d_gnt) || (if_gnt & d_gnt)) begin
                errors++;
                $display("FAIL issue_window cyc=%0d: mem_en=%b if_gnt=%b d_gnt=%b, required mem_en only with exactly one gnt",
                         cyc, mem_en, if_gnt, d_gnt);
            end
            if (if_valid) begin
                checks++;
                if (if_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL if_valid_unexpected cyc=%0d: rdata=%h, required no valid", cyc, if_rdata);
                end else begin
                    e = if_exp_q.pop_front();
                    if (if_rdata !== e[31:0] || cyc != int'(e[63:32])) begin
                        errors++;
                        $display("FAIL if_read: cyc=%0d rdata=%h, required cyc=%0d rdata=%h",
                                 cyc, if_rdata, e[63:32], e[31:0]);
                    end
                end
            end
            if (d_valid) begin
                checks++;
                if (d_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL d_valid_unexpected cyc=%0d: rdata=%h, required no valid", cyc, d_rdata);
                end else begin
                    e = d_exp_q.pop_front();
                    if (d_rdata !== e[31:0] || cyc != int'(e[63:32])) begin
                        errors++;
                        $display("FAIL d_read: cyc=%0d rdata=%h, required cyc=%0d rdata=%h",
                                 cyc, d_rdata, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int gi;
        int gd;
        int gd_arr[6];
        int n_before;
        int exp_before;
        int n;

        seed    = $urandom;
        rst_n   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        reinit_ref();

        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("idle_after_reset");

        // Fetch of word 1.
        if_access(8'h04, gi);
        drain("fetch");

        // Store then fetch back.
        d_access(1'b1, 8'h08, 32'hDEADBEEF, gd);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL store_two_states: busy=%b one cycle after store gnt, required 0", busy);
        end
        if_access(8'h08, gi);
        drain("store_fetch");

        // Conflict: D wins, IF follows on the next IDLE.
        fork
            if_access(8'h00, gi);
            d_access(1'b0, 8'h10, 32'h0, gd);
        join
        checks++;
        if (gi != gd + 3) begin
            errors++;
            $display("FAIL conflict_order: d_gnt cyc=%0d if_gnt cyc=%0d, required if_gnt = d_gnt+3", gd, gi);
        end
        drain("conflict");

        // Back-to-back D loads with IF held.
        fork
            if_access(8'h20, gi);
            begin
                for (int k = 0; k < 6; k++) d_access(1'b0, 8'(k * 4 + 1), 32'h0, gd_arr[k]);
            end
        join
        n_before = 0;
        for (int k = 0; k < 6; k++) if (gd_arr[k] < gi) n_before++;
`ifdef ARB_FAIRNESS_EN
        exp_before = MAX_WAIT;
`else
        exp_before = 6;
`endif
        checks++;
        if (n_before != exp_before) begin
            errors++;
            $display("FAIL fairness: %0d D grants before IF grant, required %0d", n_before, exp_before);
        end
        drain("fairness");

        // Reset during WAIT of a load.
        @(negedge clk);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 8'h10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_gnt && n < TIMEOUT);
        d_req = 1'b0;
        checks++;
        if (!d_gnt) begin
            errors++;
            $display("FAIL reset_load_gnt: no grant in %0d cycles, required a grant", TIMEOUT);
        end else begin
            d_acc_cnt++;
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("reset_mid_wait");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        reinit_ref();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (d_valid !== 1'b0 || if_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet: d_valid=%b if_valid=%b busy=%b, required 0 0 0",
                         d_valid, if_valid, busy);
            end
        end

        // Randomised mix.
        fork
            begin
                int g;
                for (int k = 0; k < 60; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    if_access(8'($urandom), g);
                end
            end
            begin
                int g;
                for (int k = 0; k < 80; k++) begin
                    repeat ($urandom_range(2, 5)) @(negedge clk);
                    d_access(1'($urandom_range(0, 1)), 8'($urandom), $urandom, g);
                end
            end
        join
        drain("random");

        checks++;
        if (if_gnt_cnt != if_acc_cnt || d_gnt_cnt != d_acc_cnt) begin
            errors++;
            $display("FAIL gnt_count: if_gnt=%0d d_gnt=%0d, required if=%0d d=%0d",
                     if_gnt_cnt, d_gnt_cnt, if_acc_cnt, d_acc_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule
